logic_op_pipe: RTL and testbench

- Parametrised successor of the single-bit XOR demo block.
- Computes a selectable bitwise operation on two WIDTH-bit operands and presents it three ways:
  - combinationally;
  - registered every cycle;
  - through a DEPTH-stage valid/ready pipeline with backpressure and a completed-beat counter.
- Serves as the reference datapath for teaching and regression of comb, seq and handshake code generation.

---
 rtl/logic_op_pkg.sv | 25 ++
 rtl/logic_op_stage.sv | 60 ++++++
 rtl/logic_op_pipe.sv | 119 +++++++++++
 tb/tb_logic_op_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared types and the bitwise operation used by the comb, registered and
// pipelined result paths of logic_op_pipe.
package logic_op_pkg;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_XNOR = 2'd3
    } op_e;

    // Evaluated per bit so every caller stays exactly WIDTH bits wide.
    function automatic logic apply_op(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XNOR: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_stage.sv
// One valid/data/parity slot of the handshake pipeline; loads from its
// predecessor whenever the advance signal is high.
module logic_op_stage
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             parity_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             parity_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             parity_q, parity_d;

    // Next state: data only moves with a valid beat so an empty slot keeps
    // showing its last real result instead of upstream garbage.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        parity_d = parity_q;
        if (adv_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d   = data_i;
                parity_d = parity_i;
            end else begin
                data_d   = data_q;
                parity_d = parity_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            parity_q <= parity_d;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign parity_o = parity_q;

endmodule

// File: rtl/logic_op_pipe.sv
// Selectable bitwise operation presented combinationally, registered every
// cycle, and through a DEPTH-stage valid/ready pipeline with a beat counter.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_comb,
    output logic [WIDTH-1:0] out_ff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pipe,
    output logic             out_parity,
    output logic [CNT_W-1:0] beat_count
);

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    op_e              op_s;
    logic [WIDTH-1:0] f_s;
    logic [WIDTH-1:0] out_ff_q, out_ff_d;
    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] adv_s;
    logic [DEPTH-1:0] parity_s;
    logic [WIDTH-1:0] data_s [DEPTH];
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             out_hs_s;

    assign op_s = op_e'(op);

    // Bitwise result shared by every output path.
    always_comb begin
        f_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            f_s[i] = apply_op(op_s, a[i], b[i]);
        end
    end

    // Advance chain unrolled from the output end: a stage may load if it or
    // any stage downstream of it is empty, or the sink is ready.
    always_comb begin
        logic acc;
        adv_s = '0;
        acc   = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc      = acc | ~valid_s[i];
            adv_s[i] = acc;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             vin_s;
        logic [WIDTH-1:0] din_s;
        logic             pin_s;
        if (g == 0) begin : g_head
            assign vin_s = in_valid;
            assign din_s = f_s;
            assign pin_s = parity_of(f_s);
        end else begin : g_body
            assign vin_s = valid_s[g-1];
            assign din_s = data_s[g-1];
            assign pin_s = parity_s[g-1];
        end
        logic_op_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv_i    (adv_s[g]),
            .valid_i  (vin_s),
            .data_i   (din_s),
            .parity_i (pin_s),
            .valid_o  (valid_s[g]),
            .data_o   (data_s[g]),
            .parity_o (parity_s[g])
        );
    end

    assign out_hs_s = valid_s[DEPTH-1] & out_ready;

    // Next state for the free-running register and the wrapping beat counter.
    always_comb begin
        out_ff_d = f_s;
        if (out_hs_s) begin
            beat_d = beat_q + CNT_W'(1);
        end else begin
            beat_d = beat_q;
        end
    end

    // Registered result and completed-beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ff_q <= '0;
            beat_q   <= '0;
        end else begin
            out_ff_q <= out_ff_d;
            beat_q   <= beat_d;
        end
    end

    assign out_comb   = f_s;
    assign out_ff     = out_ff_q;
    assign in_ready   = adv_s[0];
    assign out_valid  = valid_s[DEPTH-1];
    assign out_pipe   = data_s[DEPTH-1];
    assign out_parity = parity_s[DEPTH-1];
    assign beat_count = beat_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed plus short random bench for logic_op_pipe with a result scoreboard.
module tb_logic_op_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a, b;
    logic [1:0]       op;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] out_comb, out_ff, out_pipe;
    logic             out_valid, out_ready, out_parity;
    logic [CNT_W-1:0] beat_count;

    logic_op_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .op         (op),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_comb   (out_comb),
        .out_ff     (out_ff),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pipe   (out_pipe),
        .out_parity (out_parity),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             p;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    bit               chk_lat = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;

    function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        case (o)
            2'd0:    return x ^ y;
            2'd1:    return x & y;
            2'd2:    return x | y;
            default: return ~(x ^ y);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes mid-cycle, score them, then step past the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("pipe_data", 32'(out_pipe), 32'(e.d));
                chk("pipe_parity", 32'(out_parity), 32'(e.p));
                if (chk_lat) chk("pipe_latency", 32'(cyc - e.cyc), 32'(DEPTH));
            end
            exp_cnt = exp_cnt + 4'd1;
        end
        if (in_valid && in_ready) begin
            e.d = model(op, a, b);
            e.p = ^e.d;
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("beat_count", 32'(beat_count), 32'(exp_cnt));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ev;
        logic [WIDTH-1:0] hold_d;
        rst_n = 1'b0; a = '0; b = '0; op = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_ff", 32'(out_ff), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pipe", 32'(out_pipe), 32'd0);
        chk("rst_out_parity", 32'(out_parity), 32'd0);
        chk("rst_beat_count", 32'(beat_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Comb and registered paths over all four ops.
        a = 8'hF0; b = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            op = 2'(k);
            ev = model(op, a, b);
            #1;
            chk("out_comb", 32'(out_comb), 32'(ev));
            tick();
            chk("out_ff", 32'(out_ff), 32'(ev));
        end
        chk("comb_xnor_const", 32'(out_comb), 32'h33);

        // Back-to-back streaming with out_ready held high.
        chk_lat = 1'b1; out_ready = 1'b1; op = 2'd0; b = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            a = 8'(k); in_valid = 1'b1;
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("stream_count", 32'(beat_count), 32'd4);
        chk("stream_last", 32'(out_pipe), 32'h04);
        chk_lat = 1'b0;

        // Fill with out_ready low, stall, then release with a simultaneous in/out beat.
        out_ready = 1'b0; op = 2'd0; b = 8'h0F;
        a = 8'h11; in_valid = 1'b1; tick();
        a = 8'h22; tick();
        hold_d = sb[0].d;
        a = 8'h33;
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_pipe", 32'(out_pipe), 32'(hold_d));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd1);
        tick();
        drain();
        chk("bp_count", 32'(beat_count), 32'd7);

        // Op change after acceptance must not affect the in-flight beat.
        a = 8'hFF; b = 8'h0F; op = 2'd1; in_valid = 1'b1; tick();
        op = 2'd2; in_valid = 1'b0; tick();
        chk("opsamp_valid", 32'(out_valid), 32'd1);
        chk("opsamp_data", 32'(out_pipe), 32'h0F);
        chk("opsamp_parity", 32'(out_parity), 32'd0);
        tick();
        chk("idle_hold", 32'(out_pipe), 32'h0F);

        // Reset with two beats in flight, asserted mid-cycle.
        op = 2'd0; a = 8'h5A; b = 8'h00; in_valid = 1'b1; tick();
        a = 8'hA5; tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(beat_count), 32'd0);
        chk("mid_rst_out_ff", 32'(out_ff), 32'd0);
        sb.delete();
        exp_cnt = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Counter wrap: 17 handshakes from reset.
        chk_lat = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("wrap_count", 32'(beat_count), 32'd1);
        chk_lat = 1'b0;

        // Random traffic with random backpressure.
        for (int k = 0; k < 60; k++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
